// File: rtl/gpio_cfg_loader.sv
// -----------------------------------------------------------------------------
// gpio_cfg_loader
//
// Holds one MODE_W-bit mode word per user GPIO pad and, on request, shifts the
// whole set serially into the pad-control chain. After the last bit it pulses
// serial_load so the chain latches the new configuration.
//
// Bit order on serial_data: bit MODE_W-1 of pad NUM_IO-1 goes out first and
// bit 0 of pad 0 goes out last. Each pad word is sent MSB-first, starting with
// the highest pad.
//
// Optional build macro:
//   GPIO_CFG_AUTOLOAD_EN - the first clk edge after rst_n is released acts as
//                          an internal start, so the RESET_MODE image reaches
//                          the pads without any software action.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset. Release is expected to
//                     be synchronised to clk by the reset network.
//   wr_en        in   write strobe into the mode register file
//   wr_addr      in   pad index for the write
//   wr_data      in   mode word for the write
//   wr_err       out  one-cycle pulse: the write was rejected (busy or bad index)
//   start        in   single-cycle request for a chain load
//   busy         out  a load is in progress
//   done         out  one-cycle pulse: the load is complete
//   serial_clock out  chain shift clock
//   serial_data  out  chain data. It changes only while serial_clock is low.
//   serial_load  out  chain latch strobe, CLK_DIV cycles wide
//
// All outputs come straight from flops. They therefore follow the sequencer
// state with one cycle of latency.
// -----------------------------------------------------------------------------
module gpio_cfg_loader #(
    parameter int                NUM_IO     = 12,
    parameter int                MODE_W     = 12,
    parameter int                CLK_DIV    = 4,
    parameter logic [MODE_W-1:0] RESET_MODE = 12'h4C1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(NUM_IO)-1:0] wr_addr,
    input  logic [MODE_W-1:0]         wr_data,
    output logic                      wr_err,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      serial_clock,
    output logic                      serial_data,
    output logic                      serial_load
);

    // -------------------------------------------------------------------------
    // Derived sizes and constants
    // -------------------------------------------------------------------------
    localparam int AW    = $clog2(NUM_IO);
    localparam int TOTAL = NUM_IO * MODE_W;
    localparam int BIT_W = $clog2(TOTAL + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [BIT_W-1:0] BIT_TOTAL = BIT_W'(TOTAL);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [AW:0]      NUM_IO_L  = (AW + 1)'(NUM_IO);

    // Sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SH_LO = 3'd1;
    localparam logic [2:0] ST_SH_HI = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [MODE_W-1:0] mode_r [NUM_IO];
    logic [TOTAL-1:0]  shift_r;
    logic [2:0]        state_r;
    logic [DIV_W-1:0]  div_cnt_r;
    logic [BIT_W-1:0]  bit_cnt_r;

    logic              wr_err_r;
    logic              busy_r;
    logic              done_r;
    logic              serial_clock_r;
    logic              serial_data_r;
    logic              serial_load_r;

    // Next-state and helper signals
    logic [TOTAL-1:0]  image_s;
    logic [TOTAL-1:0]  shift_s;
    logic [2:0]        state_s;
    logic [DIV_W-1:0]  div_cnt_s;
    logic [BIT_W-1:0]  bit_cnt_s;
    logic [BIT_W-1:0]  bit_cnt_inc_s;
    logic              phase_end_s;
    logic              addr_ok_s;
    logic              wr_ok_s;
    logic              start_s;

    // -------------------------------------------------------------------------
    // Start source: external pulse, optionally merged with a one-shot request
    // that fires on the first edge after reset release.
    // -------------------------------------------------------------------------
`ifdef GPIO_CFG_AUTOLOAD_EN
    logic auto_pend_r;

    // One-shot internal start, armed by reset and consumed on the first edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_pend_r <= 1'b1;
        end else begin
            auto_pend_r <= 1'b0;
        end
    end

    assign start_s = start | auto_pend_r;
`else
    assign start_s = start;
`endif

    // -------------------------------------------------------------------------
    // Write qualification: only accepted while idle and for an existing pad
    // -------------------------------------------------------------------------
    assign addr_ok_s = ({1'b0, wr_addr} < NUM_IO_L);
    assign wr_ok_s   = wr_en && (state_r == ST_IDLE) && addr_ok_s;

    // Flatten the register file into the chain image, highest pad in the MSBs
    always_comb begin
        image_s = {TOTAL{1'b0}};
        for (int p = 0; p < NUM_IO; p++) begin
            image_s[p*MODE_W +: MODE_W] = mode_r[p];
        end
    end

    assign phase_end_s   = (div_cnt_r == DIV_LAST);
    assign bit_cnt_inc_s = bit_cnt_r + BIT_W'(1);

    // Sequencer next-state, divider, bit counter and shift register
    always_comb begin
        state_s   = state_r;
        div_cnt_s = div_cnt_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        case (state_r)
            ST_IDLE: begin
                div_cnt_s = {DIV_W{1'b0}};
                bit_cnt_s = {BIT_W{1'b0}};
                if (start_s) begin
                    // A write in this same cycle lands in mode_r but not in
                    // this snapshot, because image_s still shows the old file.
                    state_s = ST_SH_LO;
                    shift_s = image_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SH_LO: begin
                if (phase_end_s) begin
                    div_cnt_s = {DIV_W{1'b0}};
                    state_s   = ST_SH_HI;
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_SH_HI: begin
                if (phase_end_s) begin
                    div_cnt_s = {DIV_W{1'b0}};
                    bit_cnt_s = bit_cnt_inc_s;
                    // Advance to the next bit only once the high phase is
                    // over, so data stays put while serial_clock is high.
                    shift_s   = {shift_r[TOTAL-2:0], 1'b0};
                    if (bit_cnt_inc_s < BIT_TOTAL) begin
                        state_s = ST_SH_LO;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_LOAD: begin
                if (phase_end_s) begin
                    div_cnt_s = {DIV_W{1'b0}};
                    state_s   = ST_DONE;
                end else begin
                    div_cnt_s = div_cnt_r + DIV_W'(1);
                end
            end
            ST_DONE: begin
                div_cnt_s = {DIV_W{1'b0}};
                bit_cnt_s = {BIT_W{1'b0}};
                state_s   = ST_IDLE;
            end
            default: begin
                div_cnt_s = {DIV_W{1'b0}};
                bit_cnt_s = {BIT_W{1'b0}};
                state_s   = ST_IDLE;
            end
        endcase
    end

    // Sequencer and shift-path state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {TOTAL{1'b0}};
        end else begin
            state_r   <= state_s;
            div_cnt_r <= div_cnt_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
        end
    end

    // Mode register file: every pad returns to RESET_MODE on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_IO; p++) begin
                mode_r[p] <= RESET_MODE;
            end
        end else begin
            if (wr_ok_s) begin
                mode_r[wr_addr] <= wr_data;
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Registered outputs decoded from the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_r       <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            serial_clock_r <= 1'b0;
            serial_data_r  <= 1'b0;
            serial_load_r  <= 1'b0;
        end else begin
            wr_err_r       <= wr_en && !wr_ok_s;
            busy_r         <= (state_r == ST_SH_LO) || (state_r == ST_SH_HI) ||
                              (state_r == ST_LOAD);
            done_r         <= (state_r == ST_DONE);
            serial_clock_r <= (state_r == ST_SH_HI);
            serial_load_r  <= (state_r == ST_LOAD);
            if ((state_r == ST_SH_LO) || (state_r == ST_SH_HI)) begin
                serial_data_r <= shift_r[TOTAL-1];
            end else begin
                serial_data_r <= 1'b0;
            end
        end
    end

    assign wr_err       = wr_err_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign serial_clock = serial_clock_r;
    assign serial_data  = serial_data_r;
    assign serial_load  = serial_load_r;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_gpio_cfg_loader
//
// Bench for gpio_cfg_loader with the default parameters.
//
// Register writes come from a table of {write, expected wr_err} records. Every
// chain load pushes the image predicted by the bench-side pad model onto a
// scoreboard queue. When done arrives, that image is popped and compared with
// the bitstream captured on the serial_clock rising edges. The aborted load
// and the out-of-phase start/write cases are written out by hand.
// -----------------------------------------------------------------------------
module tb_gpio_cfg_loader;

    localparam int NUM_IO  = 12;
    localparam int MODE_W  = 12;
    localparam int CLK_DIV = 4;
    localparam int TOTAL   = NUM_IO * MODE_W;
    localparam int LAT     = 1 + 2 * CLK_DIV * TOTAL + CLK_DIV;   // 1157

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [MODE_W-1:0] wr_data;
    logic              wr_err;
    logic              start;
    logic              busy;
    logic              done;
    logic              serial_clock;
    logic              serial_data;
    logic              serial_load;

    gpio_cfg_loader #(
        .NUM_IO     (NUM_IO),
        .MODE_W     (MODE_W),
        .CLK_DIV    (CLK_DIV),
        .RESET_MODE (12'h4C1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_err       (wr_err),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .serial_clock (serial_clock),
        .serial_data  (serial_data),
        .serial_load  (serial_load)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- chain monitor (samples on the falling clk edge) --------
    logic             mon_clr   = 1'b0;
    logic             sclk_prev = 1'b0;
    logic             data_prev = 1'b0;
    logic             load_prev = 1'b0;
    logic [TOTAL-1:0] cap_bits  = '0;
    int               edge_cnt    = 0;
    int               load_pulses = 0;
    int               load_hi     = 0;
    int               done_cnt    = 0;
    int               glitch      = 0;

    always @(negedge clk) begin
        if (mon_clr) begin
            cap_bits    <= '0;
            edge_cnt    <= 0;
            load_pulses <= 0;
            load_hi     <= 0;
            done_cnt    <= 0;
            glitch      <= 0;
        end else begin
            if (serial_clock && !sclk_prev) begin
                cap_bits <= {cap_bits[TOTAL-2:0], serial_data};
                edge_cnt <= edge_cnt + 1;
            end
            if (serial_clock && sclk_prev && (serial_data != data_prev))
                glitch <= glitch + 1;
            if (serial_load)
                load_hi <= load_hi + 1;
            if (serial_load && !load_prev)
                load_pulses <= load_pulses + 1;
            if (done)
                done_cnt <= done_cnt + 1;
        end
        sclk_prev <= serial_clock;
        data_prev <= serial_data;
        load_prev <= serial_load;
    end

    // ---------------- checking helpers ---------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [TOTAL-1:0] act,
                         input logic [TOTAL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [MODE_W-1:0] model [NUM_IO];
    logic [TOTAL-1:0]  exp_q [$];

    function automatic logic [TOTAL-1:0] model_image();
        logic [TOTAL-1:0] img;
        img = '0;
        for (int p = 0; p < NUM_IO; p++) img[p*MODE_W +: MODE_W] = model[p];
        return img;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NUM_IO; p++) model[p] = 12'h4C1;
    endtask

    // Hold reset for a few cycles, check the reset values, then release it.
    // The task returns 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   144'(busy),         144'(0));
        check("rst_done",   144'(done),         144'(0));
        check("rst_wr_err", 144'(wr_err),       144'(0));
        check("rst_sclk",   144'(serial_clock), 144'(0));
        check("rst_sdata",  144'(serial_data),  144'(0));
        check("rst_sload",  144'(serial_load),  144'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // A full load. It must be entered 1 time unit after a rising edge.
    // The next edge, k, is the edge at which start (or the autoload) is
    // sampled. Optional extras:
    //   sc_wr     - a write issued in the same cycle as start
    //   mid_start - a second start pulse at loop cycle 200
    //   mid_wr    - a write issued at loop cycle 200, while busy
    task automatic run_load(input bit do_start, input bit sc_wr,
                            input logic [3:0] sc_addr, input logic [11:0] sc_data,
                            input bit mid_start, input bit mid_wr,
                            input logic [3:0] mw_addr, input logic [11:0] mw_data);
        int  k;
        int  done_cyc;
        bit  seen;
        k = cyc + 1;
        exp_q.push_back(model_image());
        mon_clr = 1'b1;
        if (do_start) start = 1'b1;
        if (sc_wr) begin
            wr_en   = 1'b1;
            wr_addr = sc_addr;
            wr_data = sc_data;
            model[sc_addr] = sc_data;
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        wr_en   = 1'b0;
        mon_clr = 1'b0;
        @(negedge clk);
        check("busy_at_k",   144'(busy),   144'(0));
        check("wr_err_at_k", 144'(wr_err), 144'(0));
        @(negedge clk);
        check("busy_at_k1",  144'(busy),   144'(1));
        seen     = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
            if (i == 200) begin
                if (mid_start) start = 1'b1;
                if (mid_wr) begin
                    wr_en   = 1'b1;
                    wr_addr = mw_addr;
                    wr_data = mw_data;
                end
            end
            if (i == 201) begin
                start = 1'b0;
                wr_en = 1'b0;
                if (mid_wr) check("busy_wr_err", 144'(wr_err), 144'(1));
            end
            if (i == 202 && mid_wr) check("busy_wr_err_end", 144'(wr_err), 144'(0));
        end
        check("done_seen", 144'(seen), 144'(1));
        check("done_latency", 144'(done_cyc - k), 144'(LAT));
        repeat (3) @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 144'(0), 144'(1));
        end else begin
            check("bitstream", cap_bits, exp_q.pop_front());
        end
        check("sclk_edges",  144'(edge_cnt),    144'(TOTAL));
        check("load_pulses", 144'(load_pulses), 144'(1));
        check("load_width",  144'(load_hi),     144'(CLK_DIV));
        check("done_pulses", 144'(done_cnt),    144'(1));
        check("data_stable", 144'(glitch),      144'(0));
        check("busy_after",  144'(busy),        144'(0));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  addr;
        logic [11:0] data;
        logic        err;
    } wr_vec_t;

    wr_vec_t vecs [8];

    initial begin
        vecs[0] = '{en: 1'b1, addr: 4'd11, data: 12'h2C6, err: 1'b0};
        vecs[1] = '{en: 1'b1, addr: 4'd0,  data: 12'h006, err: 1'b0};
        vecs[2] = '{en: 1'b1, addr: 4'd13, data: 12'hB86, err: 1'b1};
        vecs[3] = '{en: 1'b1, addr: 4'd12, data: 12'h123, err: 1'b1};
        vecs[4] = '{en: 1'b1, addr: 4'd15, data: 12'hFFF, err: 1'b1};
        vecs[5] = '{en: 1'b1, addr: 4'd5,  data: 12'h2C6, err: 1'b0};
        vecs[6] = '{en: 1'b1, addr: 4'd5,  data: 12'h4C1, err: 1'b0};
        vecs[7] = '{en: 1'b0, addr: 4'd3,  data: 12'hFFF, err: 1'b0};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 4'd0;
        wr_data = 12'h000;
        start   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Test 1 / 6: first load with the reset image
`ifdef GPIO_CFG_AUTOLOAD_EN
        run_load(1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 12'h000);
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_autoload", 144'(busy), 144'(0));
            @(posedge clk);
            #1;
        end
        run_load(1'b1, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 12'h000);
`endif

        // Table of register writes issued while idle
        for (int v = 0; v < 8; v++) begin
            wr_en   = vecs[v].en;
            wr_addr = vecs[v].addr;
            wr_data = vecs[v].data;
            @(posedge clk);
            #1 wr_en = 1'b0;
            @(negedge clk);
            check($sformatf("wr_err_vec%0d", v), 144'(wr_err), 144'(vecs[v].err));
            if (vecs[v].en && !vecs[v].err) model[vecs[v].addr] = vecs[v].data;
            @(posedge clk);
            #1;
        end

        // Test 2: pad 11 = 2C6 first out, pad 0 = 006 last out
        run_load(1'b1, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 12'h000);

        // Test 3: write pad 1 in the start cycle (left out of this load) and
        // pad 3 while busy (rejected)
        run_load(1'b1, 1'b1, 4'd1, 12'h2C6, 1'b0, 1'b1, 4'd3, 12'hB86);

        // Test 4: a second start mid-load is ignored. This load must show
        // pad 1 = 2C6 and pad 3 still 4C1.
        run_load(1'b1, 1'b0, 4'd0, 12'h000, 1'b1, 1'b0, 4'd0, 12'h000);

        // Test 5: reset after bit 70 aborts the load with no serial_load
        mon_clr = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mon_clr = 1'b0;
        for (int i = 0; i < 2000 && edge_cnt < 70; i++) @(negedge clk);
        check("reached_bit70", 144'(edge_cnt >= 70), 144'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",  144'(busy),         144'(0));
        check("abort_sclk",  144'(serial_clock), 144'(0));
        check("abort_sdata", 144'(serial_data),  144'(0));
        check("abort_sload", 144'(serial_load),  144'(0));
        check("abort_done",  144'(done),         144'(0));
        repeat (4) @(negedge clk);
        check("abort_no_load", 144'(load_pulses), 144'(0));
        check("abort_no_done", 144'(done_cnt),    144'(0));
        check("abort_partial", 144'(edge_cnt < TOTAL), 144'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
`ifdef GPIO_CFG_AUTOLOAD_EN
        run_load(1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 12'h000);
`else
        run_load(1'b1, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 4'd0, 12'h000);
`endif

        check("scoreboard_drained", 144'(exp_q.size()), 144'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
